// File: rtl/char_row_blitter.sv
// char_row_blitter: draws one glyph into the framebuffer, one row at a time.
// For each glyph row it fetches the row bits from a synchronous font ROM, pulses row_start_o
// to launch the external row counter, then turns the counter's one-hot column vector into
// registered pixel writes. Rows advance on row_finish_i until the whole glyph is drawn.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   draw_req_i                       draw request, sampled only while idle
//   draw_x_i, draw_y_i               glyph top-left screen position
//   char_code_i                      glyph index into the font ROM
//   fg_color_i, bg_color_i           colours for set / clear glyph bits
//   busy_o, done_o, err_o            status; done_o and err_o are one-cycle pulses
//   rom_addr_o, rom_data_i           font ROM port (data one cycle after address)
//   row_start_o                      start pulse to the row counter
//   col_onehot_i, row_finish_i       row counter count register and finish flag
//   pix_we_o, pix_addr_o, pix_data_o registered framebuffer write port
module char_row_blitter #(
  parameter int unsigned CHAR_WIDTH    = 20,
  parameter int unsigned CHAR_HEIGHT   = 20,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned ADDR_WIDTH    = 19,
  parameter int unsigned ROM_AW        = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  draw_req_i,
  input  logic [9:0]            draw_x_i,
  input  logic [8:0]            draw_y_i,
  input  logic [7:0]            char_code_i,
  input  logic [7:0]            fg_color_i,
  input  logic [7:0]            bg_color_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic [CHAR_WIDTH-1:0] rom_data_i,
  output logic                  row_start_o,
  input  logic [31:0]           col_onehot_i,
  input  logic                  row_finish_i,
  output logic                  pix_we_o,
  output logic [ADDR_WIDTH-1:0] pix_addr_o,
  output logic [7:0]            pix_data_o
);

  localparam int unsigned RowW = (CHAR_HEIGHT > 1) ? $clog2(CHAR_HEIGHT) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StStart, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [CHAR_WIDTH-1:0] row_bits_q, row_bits_d;
  logic [9:0]            x_q, x_d;
  logic [8:0]            y_q, y_d;
  logic [7:0]            code_q, code_d;
  logic [7:0]            fg_q, fg_d;
  logic [7:0]            bg_q, bg_d;
  logic                  pix_we_q, pix_we_d;
  logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]            pix_data_q, pix_data_d;

  logic [4:0]  col;
  logic        col_vld;
  logic        glyph_bit;
  logic [31:0] scr_x, scr_y;
  logic        clip;

  // Lowest set bit of the counter vector; a zero vector is a protocol fault.
  always_comb begin
    col     = '0;
    col_vld = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (col_onehot_i[i]) begin
        col     = 5'(i);
        col_vld = 1'b1;
      end
    end
  end

  // Column 0 is the MSB of the ROM row; columns beyond the glyph read as background.
  always_comb begin
    glyph_bit = 1'b0;
    for (int i = 0; i < int'(CHAR_WIDTH); i++) begin
      if (32'(col) == 32'(i)) begin
        glyph_bit = row_bits_q[CHAR_WIDTH-1-i];
      end
    end
  end

  // Offsets are added at full width so off-screen pixels are detected before truncation.
  assign scr_x = 32'(x_q) + 32'(col);
  assign scr_y = 32'(y_q) + 32'(row_q);
  assign clip  = (scr_x >= SCREEN_WIDTH) || (scr_y >= SCREEN_HEIGHT);

  assign rom_addr_o = ROM_AW'(32'(code_q) * CHAR_HEIGHT + 32'(row_q));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_bits_d  = row_bits_q;
    x_d         = x_q;
    y_d         = y_q;
    code_d      = code_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    pix_we_d    = 1'b0;
    pix_addr_d  = pix_addr_q;
    pix_data_d  = pix_data_q;
    busy_o      = (state_q != StIdle);
    done_o      = 1'b0;
    err_o       = 1'b0;
    row_start_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (draw_req_i) begin
          x_d     = draw_x_i;
          y_d     = draw_y_i;
          code_d  = char_code_i;
          fg_d    = fg_color_i;
          bg_d    = bg_color_i;
          row_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StStart;
      end
      StStart: begin
        row_bits_d  = rom_data_i;
        row_start_o = 1'b1;
        state_d     = StRun;
      end
      StRun: begin
        if (!col_vld) begin
          err_o   = 1'b1;
          state_d = StIdle;
        end else begin
          pix_we_d   = !clip;
          pix_addr_d = ADDR_WIDTH'(scr_y * SCREEN_WIDTH + scr_x);
          pix_data_d = glyph_bit ? fg_q : bg_q;
          if (row_finish_i) begin
            if (row_q == RowW'(CHAR_HEIGHT - 1)) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + RowW'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      row_q      <= '0;
      row_bits_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      code_q     <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      row_bits_q <= row_bits_d;
      x_q        <= x_d;
      y_q        <= y_d;
      code_q     <= code_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
    end
  end

  assign pix_we_o   = pix_we_q;
  assign pix_addr_o = pix_addr_q;
  assign pix_data_o = pix_data_q;

endmodule

// File: tb/tb_char_row_blitter.sv
// Bench for char_row_blitter: random glyph draws against a loop-based reference model, with a
// behavioural row counter and font ROM around the DUT.
module tb_char_row_blitter;

  localparam int CW  = 20;
  localparam int CH  = 20;
  localparam int SW  = 640;
  localparam int SH  = 480;
  localparam int AW  = 19;
  localparam int RAW = 13;
  localparam int BUSY_LEN = CH * (CW + 2) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          draw_req = 1'b0;
  logic [9:0]    draw_x = '0;
  logic [8:0]    draw_y = '0;
  logic [7:0]    char_code = '0;
  logic [7:0]    fg_color = '0;
  logic [7:0]    bg_color = '0;
  logic          busy, done, err, row_start, row_finish, pix_we;
  logic [RAW-1:0] rom_addr;
  logic [CW-1:0] rom_data = '0;
  logic [31:0]   col_onehot;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_data;

  always #5 clk = ~clk;

  char_row_blitter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .draw_req_i   (draw_req),
    .draw_x_i     (draw_x),
    .draw_y_i     (draw_y),
    .char_code_i  (char_code),
    .fg_color_i   (fg_color),
    .bg_color_i   (bg_color),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .row_start_o  (row_start),
    .col_onehot_i (col_onehot),
    .row_finish_i (row_finish),
    .pix_we_o     (pix_we),
    .pix_addr_o   (pix_addr),
    .pix_data_o   (pix_data)
  );

  // Behavioural row counter: loads 1 on row_start, walks up to the last column, then clears.
  logic [31:0] cnt = '0;
  logic        force_zero = 1'b0;
  always @(posedge clk) begin
    if (row_start) cnt <= 32'd1;
    else if (cnt[CW-1]) cnt <= '0;
    else cnt <= cnt << 1;
  end
  assign col_onehot = force_zero ? 32'd0 : cnt;
  assign row_finish = col_onehot[CW-1];

  // Synchronous font ROM.
  logic [CW-1:0] rom [0:(1<<RAW)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad = 0;
  int exp_code = 0;
  int exp_wr = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rs_cnt = 0;
  int last_gap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: every on-screen pixel of the glyph, in raster order.
  task automatic push_glyph(input int x, input int y, input int code,
                            input logic [7:0] fg, input logic [7:0] bg);
    int n = 0;
    for (int r = 0; r < CH; r++) begin
      for (int c = 0; c < CW; c++) begin
        logic [CW-1:0] bits;
        wr_t e;
        bits = rom[code * CH + r] >> (CW - 1 - c);
        if (x + c < SW && y + r < SH) begin
          e.addr = AW'((y + r) * SW + (x + c));
          e.data = bits[0] ? fg : bg;
          exp_q.push_back(e);
          n++;
        end
      end
    end
    exp_code = code;
    exp_wr   = n;
  endtask

  // Monitor / scoreboard.
  initial begin
    int  cyc = 0;
    int  busy_cnt = 0;
    int  wr_cnt = 0;
    int  last_rs = 0;
    int  idle_gap = 0;
    logic prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) begin
        last_gap = idle_gap;
        idle_gap = 0;
        busy_cnt = 0;
        rs_cnt   = 0;
        wr_cnt   = 0;
      end
      if (!busy) idle_gap++;
      else busy_cnt++;
      if (pix_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write: got write addr=%0h data=%0h expected none", pix_addr,
                   pix_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("pix_addr", 64'(pix_addr), 64'(e.addr));
          chk("pix_data", 64'(pix_data), 64'(e.data));
        end
      end
      if (row_start) begin
        chk("rom_addr", 64'(rom_addr), 64'(exp_code * CH + rs_cnt));
        if (rs_cnt > 0) chk("row_start_gap", 64'(cyc - last_rs), 64'(CW + 2));
        last_rs = cyc;
        rs_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_len", 64'(busy_cnt), 64'(BUSY_LEN));
        chk("row_starts", 64'(rs_cnt), 64'(CH));
        chk("write_count", 64'(wr_cnt), 64'(exp_wr));
      end
      if (err) err_cnt++;
      prev_busy = busy;
    end
  end

  task automatic set_req(input int x, input int y, input int code,
                         input logic [7:0] fg, input logic [7:0] bg);
    draw_x    = 10'(x);
    draw_y    = 9'(y);
    char_code = 8'(code);
    fg_color  = fg;
    bg_color  = bg;
  endtask

  task automatic request(input int x, input int y, input int code,
                         input logic [7:0] fg, input logic [7:0] bg);
    @(negedge clk); #1;
    set_req(x, y, code, fg, bg);
    draw_req = 1'b1;
    @(negedge clk); #1;
    draw_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: got done count %0d expected %0d (timeout)", name, done_cnt, target);
    end
  endtask

  task automatic wait_rows(input int target, input string name);
    int k = 0;
    while (rs_cnt < target && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    if (rs_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: got row starts %0d expected %0d (timeout)", name, rs_cnt, target);
    end
  endtask

  task automatic glyph(input int x, input int y, input int code,
                       input logic [7:0] fg, input logic [7:0] bg, input string name);
    int d0 = done_cnt;
    push_glyph(x, y, code, fg, bg);
    request(x, y, code, fg, bg);
    wait_done(d0 + 1, name);
    @(negedge clk); #1;
  endtask

  initial begin
    int d0;
    for (int i = 0; i < (1 << RAW); i++) rom[i] = CW'($urandom);
    for (int r = 0; r < CH; r++) rom[r] = 20'hAAAAA;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_row_start", 64'(row_start), 64'(0));
    chk("rst_pix_we", 64'(pix_we), 64'(0));
    chk("rst_pix_addr", 64'(pix_addr), 64'(0));
    chk("rst_pix_data", 64'(pix_data), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    glyph(0, 0, 0, 8'hFF, 8'h00, "basic");
    glyph(100, 50, 65, 8'($urandom), 8'($urandom), "code65");
    glyph(630, 470, $urandom_range(0, 255), 8'h5A, 8'hA5, "clip");
    chk("clip_writes", 64'(exp_wr), 64'(100));
    for (int i = 0; i < 5; i++) begin
      glyph($urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 255),
            8'($urandom), 8'($urandom), "random");
    end

    // Request held through two glyphs: second accept directly after DONE.
    d0 = done_cnt;
    push_glyph(40, 30, 17, 8'h11, 8'h22);
    push_glyph(40, 30, 17, 8'h11, 8'h22);
    @(negedge clk); #1;
    set_req(40, 30, 17, 8'h11, 8'h22);
    draw_req = 1'b1;
    wait_done(d0 + 2, "held_req");
    draw_req = 1'b0;
    chk("accept_gap", 64'(last_gap), 64'(1));
    repeat (3) @(negedge clk);
    #1 chk("held_idle", 64'(busy), 64'(0));

    // Reset during row 5.
    d0 = done_cnt;
    push_glyph(200, 100, 33, 8'hC3, 8'h3C);
    request(200, 100, 33, 8'hC3, 8'h3C);
    wait_rows(6, "reset_row5");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_pix_we", 64'(pix_we), 64'(0));
    chk("mid_rst_row_start", 64'(row_start), 64'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    glyph(300, 200, $urandom_range(0, 255), 8'($urandom), 8'($urandom), "after_reset");

    // Counter vector forced to zero mid-row.
    d0 = done_cnt;
    push_glyph(64, 64, 90, 8'h77, 8'h88);
    request(64, 64, 90, 8'h77, 8'h88);
    wait_rows(4, "fault_row3");
    repeat (4) @(negedge clk);
    #1 force_zero = 1'b1;
    #1;
    chk("fault_err", 64'(err), 64'(1));
    chk("fault_busy", 64'(busy), 64'(1));
    @(negedge clk); #1;
    chk("fault_err_pulse", 64'(err), 64'(0));
    chk("fault_idle", 64'(busy), 64'(0));
    chk("fault_no_write", 64'(pix_we), 64'(0));
    force_zero = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("fault_no_done", 64'(done_cnt), 64'(d0));
    glyph($urandom_range(0, 600), $urandom_range(0, 440), $urandom_range(0, 255),
          8'($urandom), 8'($urandom), "after_fault");

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("spurious_err", 64'(err_cnt), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
